// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with per-entry saturating counters.
// IF looks up pc_IF combinationally; EX writes one resolved outcome per cycle.
// Optional feature macro: BP_STATS_EN (adds lookup/update/mispredict counters).
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] pc_IF,
  output logic            pred_taken_IF,
  output logic [XLEN-1:0] pred_target_IF,
  input  logic            upd_valid_EX,
  input  logic [XLEN-1:0] upd_pc_EX,
  input  logic            upd_uncond_EX,
  input  logic            upd_taken_EX,
  input  logic [XLEN-1:0] upd_target_EX,
  input  logic            upd_mispredict_EX
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_updates,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int INDEX_W = $clog2(ENTRIES);
  localparam int TAG_W   = XLEN - INDEX_W - 2;

  // Counter encodings: upper half predicts taken.
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_MAX >> 1;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(int'(CNT_WNT) + 1);

  // Entry storage
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [CNT_W-1:0] cnt_q    [ENTRIES];

  // Lookup side (pre-update contents, no bypass)
  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_hit;
  logic [XLEN-1:0]    pc_plus4;

  assign lk_idx         = pc_IF[INDEX_W+1:2];
  assign lk_tag         = pc_IF[XLEN-1:INDEX_W+2];
  assign lk_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pc_plus4       = pc_IF + XLEN'(4);
  assign pred_taken_IF  = lk_hit & cnt_q[lk_idx][CNT_W-1];
  assign pred_target_IF = pred_taken_IF ? target_q[lk_idx] : pc_plus4;

  // Update side
  logic [INDEX_W-1:0] upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  logic               upd_hit;
  logic               upd_t;
  logic [CNT_W-1:0]   upd_cnt_cur;

  assign upd_idx     = upd_pc_EX[INDEX_W+1:2];
  assign upd_tag     = upd_pc_EX[XLEN-1:INDEX_W+2];
  assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_t       = upd_uncond_EX | upd_taken_EX;
  assign upd_cnt_cur = cnt_q[upd_idx];

  logic             wr_en;
  logic [XLEN-1:0]  target_d;
  logic [CNT_W-1:0] cnt_d;

  // Compute the new contents of the entry addressed by the EX update.
  always_comb begin
    wr_en    = 1'b0;
    target_d = target_q[upd_idx];
    cnt_d    = upd_cnt_cur;
    if (upd_valid_EX) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (upd_uncond_EX) begin
          cnt_d    = CNT_MAX;
          target_d = upd_target_EX;
        end else if (upd_taken_EX) begin
          cnt_d    = (upd_cnt_cur == CNT_MAX) ? upd_cnt_cur : upd_cnt_cur + CNT_W'(1);
          target_d = upd_target_EX;
        end else begin
          cnt_d    = (upd_cnt_cur == '0) ? upd_cnt_cur : upd_cnt_cur - CNT_W'(1);
        end
      end else if (upd_t) begin
        // Miss on a taken outcome: allocate, evicting any aliasing entry.
        wr_en    = 1'b1;
        target_d = upd_target_EX;
        cnt_d    = upd_uncond_EX ? CNT_MAX : CNT_WT;
      end
    end
  end

  // Table registers: cleared to invalid/weakly-not-taken on reset, one write per cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
    end else if (wr_en) begin
      valid_q[upd_idx]  <= 1'b1;
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= target_d;
      cnt_q[upd_idx]    <= cnt_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_lookups_q;
  logic [31:0] stat_updates_q;
  logic [31:0] stat_mispredicts_q;

  // Free-running wrapping statistics counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_lookups_q     <= '0;
      stat_updates_q     <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_lookups_q <= stat_lookups_q + 32'd1;
      if (upd_valid_EX) begin
        stat_updates_q <= stat_updates_q + 32'd1;
      end
      if (upd_valid_EX && upd_mispredict_EX) begin
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
      end
    end
  end

  assign stat_lookups     = stat_lookups_q;
  assign stat_updates     = stat_updates_q;
  assign stat_mispredicts = stat_mispredicts_q;

  // Byte-offset bits never participate in index or tag.
  logic unused_bits;
  assign unused_bits = ^{pc_IF[1:0], upd_pc_EX[1:0]};
`else
  // Byte-offset bits and the mispredict flag have no consumer in this build.
  logic unused_bits;
  assign unused_bits = ^{pc_IF[1:0], upd_pc_EX[1:0], upd_mispredict_EX};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor (default parameters: XLEN=32, ENTRIES=16, CNT_W=2).
// Directed vector table, hand sequences for reset corner cases, then random
// traffic compared against a behavioural model. Stats checks under BP_STATS_EN.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] pc_IF;
  logic        pred_taken_IF;
  logic [31:0] pred_target_IF;
  logic        upd_valid_EX;
  logic [31:0] upd_pc_EX;
  logic        upd_uncond_EX;
  logic        upd_taken_EX;
  logic [31:0] upd_target_EX;
  logic        upd_mispredict_EX;
`ifdef BP_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(32), .ENTRIES(16), .CNT_W(2)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .pc_IF             (pc_IF),
    .pred_taken_IF     (pred_taken_IF),
    .pred_target_IF    (pred_target_IF),
    .upd_valid_EX      (upd_valid_EX),
    .upd_pc_EX         (upd_pc_EX),
    .upd_uncond_EX     (upd_uncond_EX),
    .upd_taken_EX      (upd_taken_EX),
    .upd_target_EX     (upd_target_EX),
    .upd_mispredict_EX (upd_mispredict_EX)
`ifdef BP_STATS_EN
    ,
    .stat_lookups      (stat_lookups),
    .stat_updates      (stat_updates),
    .stat_mispredicts  (stat_mispredicts)
`endif
  );

  int tests = 0;
  int fails = 0;

  // ---------------- behavioural reference model ----------------
  localparam int M_ENTRIES = 16;
  localparam int M_MAX     = 3;   // 2^CNT_W - 1
  localparam int M_WNT     = 1;   // 2^(CNT_W-1) - 1
  localparam int M_WT      = 2;

  bit          m_valid  [M_ENTRIES];
  int unsigned m_tag    [M_ENTRIES];
  logic [31:0] m_target [M_ENTRIES];
  int          m_cnt    [M_ENTRIES];

  function automatic void m_reset();
    for (int i = 0; i < M_ENTRIES; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = 0;
      m_target[i] = '0;
      m_cnt[i]   = M_WNT;
    end
  endfunction

  function automatic void m_predict(input logic [31:0] pc, output bit tk, output logic [31:0] tg);
    int          idx;
    int unsigned tag;
    idx = int'((pc / 4) % M_ENTRIES);
    tag = pc / (4 * M_ENTRIES);
    tk  = m_valid[idx] && (m_tag[idx] == tag) && (m_cnt[idx] > M_WNT);
    tg  = tk ? m_target[idx] : pc + 32'd4;
  endfunction

  function automatic void m_update(input logic [31:0] upc, input bit uc, input bit tk,
                                   input logic [31:0] utg);
    int          idx;
    int unsigned tag;
    bit          taken;
    idx   = int'((upc / 4) % M_ENTRIES);
    tag   = upc / (4 * M_ENTRIES);
    taken = uc || tk;
    if (m_valid[idx] && m_tag[idx] == tag) begin
      if (uc) begin
        m_cnt[idx] = M_MAX;
        m_target[idx] = utg;
      end else if (taken) begin
        m_cnt[idx] = (m_cnt[idx] + 1 > M_MAX) ? M_MAX : m_cnt[idx] + 1;
        m_target[idx] = utg;
      end else begin
        m_cnt[idx] = (m_cnt[idx] - 1 < 0) ? 0 : m_cnt[idx] - 1;
      end
    end else if (taken) begin
      m_valid[idx]  = 1;
      m_tag[idx]    = tag;
      m_target[idx] = utg;
      m_cnt[idx]    = uc ? M_MAX : M_WT;
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic drive(input logic [31:0] pc, input bit uv, input bit uc, input bit tk,
                       input logic [31:0] upc, input logic [31:0] utg, input bit mp);
    pc_IF             = pc;
    upd_valid_EX      = uv;
    upd_uncond_EX     = uc;
    upd_taken_EX      = tk;
    upd_pc_EX         = upc;
    upd_target_EX     = utg;
    upd_mispredict_EX = mp;
  endtask

  task automatic check(input string name, input bit exp_tk, input logic [31:0] exp_tg);
    tests++;
    if (pred_taken_IF !== exp_tk || pred_target_IF !== exp_tg) begin
      fails++;
      $display("FAIL %s: got taken=%0b target=%h, expected taken=%0b target=%h",
               name, pred_taken_IF, pred_target_IF, exp_tk, exp_tg);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] hi;
    logic [31:0] idx;
    logic [31:0] lo;
    case ($urandom_range(0, 4))
      0, 1, 2: hi = 32'($urandom_range(0, 2));
      3:       hi = 32'h03FF_FFFF;
      default: hi = 32'($urandom_range(0, 1000));
    endcase
    idx = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 3));
    lo  = 32'($urandom_range(0, 3));
    return (hi << 6) | (idx << 2) | lo;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] pc;
    bit          uv;
    bit          uc;
    bit          tk;
    logic [31:0] upc;
    logic [31:0] utg;
    bit          e_tk;
    logic [31:0] e_tg;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          mtk;
    logic [31:0] mtg;
    logic [31:0] rpc;
    logic [31:0] rupc;
    logic [31:0] rutg;
    bit          ruv;
    bit          ruc;
    bit          rtk;

    //          pc            uv uc tk upc           utg           e_tk e_tg
    vecs[0]  = '{32'h40,       0, 0, 0, 32'h0,        32'h0,        0, 32'h44};       // defaults
    vecs[1]  = '{32'h40,       1, 0, 1, 32'h40,       32'h100,      0, 32'h44};       // same-cycle: pre-update
    vecs[2]  = '{32'h40,       1, 0, 0, 32'h40,       32'h0,        1, 32'h100};      // WT -> WNT
    vecs[3]  = '{32'h40,       1, 0, 0, 32'h40,       32'h0,        0, 32'h44};       // WNT -> 0
    vecs[4]  = '{32'h40,       0, 0, 0, 32'h0,        32'h0,        0, 32'h44};       // cnt 0
    vecs[5]  = '{32'h40,       1, 0, 1, 32'h40,       32'h100,      0, 32'h44};       // 0 -> 1
    vecs[6]  = '{32'h40,       1, 0, 1, 32'h40,       32'h100,      0, 32'h44};       // 1 -> 2
    vecs[7]  = '{32'h40,       1, 0, 1, 32'h40,       32'h100,      1, 32'h100};      // 2 -> 3
    vecs[8]  = '{32'h40,       1, 0, 1, 32'h40,       32'h100,      1, 32'h100};      // 3 sat
    vecs[9]  = '{32'h40,       1, 0, 1, 32'h40,       32'h100,      1, 32'h100};      // 3 sat
    vecs[10] = '{32'h40,       1, 0, 0, 32'h40,       32'h0,        1, 32'h100};      // 3 -> 2
    vecs[11] = '{32'h40,       0, 0, 0, 32'h0,        32'h0,        1, 32'h100};      // still taken
    vecs[12] = '{32'h80,       1, 1, 0, 32'h40,       32'h200,      0, 32'h84};       // jal hit, 0x80 miss
    vecs[13] = '{32'h40,       1, 0, 1, 32'h80,       32'h300,      1, 32'h200};      // alias alloc
    vecs[14] = '{32'h40,       0, 0, 0, 32'h0,        32'h0,        0, 32'h44};       // evicted
    vecs[15] = '{32'h80,       0, 0, 0, 32'h0,        32'h0,        1, 32'h300};
    vecs[16] = '{32'hFFFF_FFFC, 0, 0, 0, 32'h0,       32'h0,        0, 32'h0};        // wrap
    vecs[17] = '{32'h80,       1, 0, 0, 32'h44,       32'h0,        1, 32'h300};      // miss nt: no alloc
    vecs[18] = '{32'h44,       0, 0, 0, 32'h0,        32'h0,        0, 32'h48};
    vecs[19] = '{32'h82,       0, 0, 0, 32'h0,        32'h0,        1, 32'h300};      // pc[1:0] ignored
    vecs[20] = '{32'h0C,       1, 1, 0, 32'h10C,      32'h500,      0, 32'h10};       // jal miss alloc
    vecs[21] = '{32'h10C,      0, 0, 0, 32'h0,        32'h0,        1, 32'h500};
    vecs[22] = '{32'h10C,      1, 0, 0, 32'h10C,      32'h0,        1, 32'h500};      // max -> 2
    vecs[23] = '{32'h10C,      0, 0, 0, 32'h0,        32'h0,        1, 32'h500};      // jal gave max

    // ---- reset state, with an update attempted while in reset ----
    rstn = 1'b0;
    drive(32'h40, 1, 0, 1, 32'h40, 32'h100, 0);
    #3;
    $display("[TB] reset pc=%h taken=%0b target=%h", pc_IF, pred_taken_IF, pred_target_IF);
    check("reset_default", 0, 32'h44);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    drive(32'h40, 0, 0, 0, 32'h0, 32'h0, 0);
    #1;
    check("reset_upd_ignored", 0, 32'h44);

    // ---- table ----
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].pc, vecs[i].uv, vecs[i].uc, vecs[i].tk, vecs[i].upc, vecs[i].utg, 0);
      @(negedge clk);
      $display("[TB] vec %0d pc=%h upd=%0b upc=%h taken=%0b target=%h",
               i, pc_IF, upd_valid_EX, upd_pc_EX, pred_taken_IF, pred_target_IF);
      check($sformatf("vec%0d", i), vecs[i].e_tk, vecs[i].e_tg);
    end

    // ---- asynchronous reset in the middle of an update ----
    @(posedge clk);
    #1;
    drive(32'h80, 1, 0, 1, 32'h80, 32'h300, 0);
    #1;
    $display("[TB] pre-reset pc=%h taken=%0b target=%h", pc_IF, pred_taken_IF, pred_target_IF);
    check("pre_reset_trained", 1, 32'h300);
    #1;
    rstn = 1'b0;
    #1;
    $display("[TB] async reset pc=%h taken=%0b target=%h", pc_IF, pred_taken_IF, pred_target_IF);
    check("async_reset_0x80", 0, 32'h84);
    pc_IF = 32'h10C;
    #1;
    $display("[TB] async reset pc=%h taken=%0b target=%h", pc_IF, pred_taken_IF, pred_target_IF);
    check("async_reset_0x10C", 0, 32'h110);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    drive(32'h80, 0, 0, 0, 32'h0, 32'h0, 0);
    #1;
    check("after_reset_0x80", 0, 32'h84);

    // ---- random traffic against the model ----
    m_reset();
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      rpc  = rand_pc();
      ruv  = ($urandom_range(0, 3) != 0);
      ruc  = ($urandom_range(0, 4) == 0);
      rtk  = ($urandom_range(0, 2) != 0);
      rupc = ($urandom_range(0, 1) == 0) ? rpc : rand_pc();
      rutg = {$urandom_range(0, 32'h3FFF), 2'b00};
      drive(rpc, ruv, ruc, rtk, rupc, rutg, 0);
      @(negedge clk);
      m_predict(rpc, mtk, mtg);
      $display("[TB] rnd %0d pc=%h upd=%0b upc=%h uc=%0b tk=%0b taken=%0b target=%h",
               n, rpc, ruv, rupc, ruc, rtk, pred_taken_IF, pred_target_IF);
      check($sformatf("rnd%0d", n), mtk, mtg);
      if (ruv) m_update(rupc, ruc, rtk, rutg);
    end

`ifdef BP_STATS_EN
    // ---- statistics counters ----
    @(negedge clk);
    rstn = 1'b0;
    drive(32'h40, 0, 0, 0, 32'h0, 32'h0, 0);
    #1;
    check32("stat_lookups_reset", stat_lookups, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(32'h40, (i < 3), 0, 1, 32'h40, 32'h100, (i == 1));
      @(posedge clk);
      #1;
    end
    drive(32'h40, 0, 0, 0, 32'h0, 32'h0, 0);
    $display("[TB] stats lookups=%0d updates=%0d mispredicts=%0d",
             stat_lookups, stat_updates, stat_mispredicts);
    check32("stat_lookups", stat_lookups, 32'd10);
    check32("stat_updates", stat_updates, 32'd3);
    check32("stat_mispredicts", stat_mispredicts, 32'd1);
    @(negedge clk);
    force dut.stat_lookups_q = 32'hFFFF_FFFF;
    #1;
    release dut.stat_lookups_q;
    @(posedge clk);
    #1;
    $display("[TB] stats wrap lookups=%h", stat_lookups);
    check32("stat_lookups_wrap", stat_lookups, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
